pedestrian_phase_controller: RTL and testbench
==============================================

PEDESTRIAN_PHASE_CONTROLLER -- requirements
Module: pedestrian_phase_controller

Interface
REQ-001 The module SHALL expose parameter CLK_FREQ, default 50_000_000, the clock frequency in Hz (passed through to the downstream timer display).
REQ-002 The module SHALL expose parameter WALK_CYCLES, default 350_000_000, the free-walk duration in clocks (range 1..2^31).
REQ-003 The module SHALL expose parameter CAUTION_CYCLES, default 500_000_000, the caution duration in clocks (range 1..2^31).
REQ-004 The module SHALL expose parameter CLEAR_CYCLES, default 100_000_000, the all-red clearance in clocks after caution (range 1..2^31).
REQ-005 The module SHALL expose parameter EXT_CYCLES, default 150_000_000, the accessible walk extension in clocks.
REQ-006 The module SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- ped_button, in, 1: synchronous request pulse.
- ext_button, in, 1: accessible-extension request.
- veh_stop, in, 1: vehicle controller holds all conflicting lanes red.
- ped_req, out, 1: request to vehicle controller.
- walk, out, 1: walk signal.
- dont_walk, out, 1: don't-walk signal.
- ped_done, out, 1: one-cycle pulse when the pedestrian phase is complete.
- pd_caution, out, 1: pedestrian phase active.
- pd_counter, out, 32: cycles elapsed in the phase.
- pd_free_cycles, out, 32: free-walk length of the current phase.
- pd_total_cycles, out, 32: free plus caution length of the current phase.
- state, out, 3: FSM state code.

Function
REQ-007 The FSM SHALL have states IDLE=0, WALK=1, CAUTION=2, CLEAR=3, all registered.
REQ-008 A ped_button high in any state except WALK SHALL set req_pending on the next edge; ped_req SHALL equal req_pending.
REQ-009 IDLE with req_pending=1 and veh_stop=1 SHALL transition to WALK on the next edge, clearing req_pending, setting pd_counter=0, and latching pd_free_cycles=WALK_CYCLES and pd_total_cycles=WALK_CYCLES+CAUTION_CYCLES.
REQ-010 In WALK and CAUTION, pd_counter SHALL increment by 1 every cycle and pd_caution SHALL be 1.
REQ-011 Walk SHALL be 1 only in WALK; dont_walk SHALL be the inverse of walk.
REQ-012 WALK SHALL transition to CAUTION on the edge where pd_counter equals pd_free_cycles-1, so the first CAUTION cycle shows pd_counter=pd_free_cycles.
REQ-013 CAUTION SHALL transition to CLEAR on the edge where pd_counter equals pd_total_cycles-1; entering CLEAR SHALL reset pd_counter to 0 and set pd_caution to 0.
REQ-014 In CLEAR, pd_counter SHALL count 0..CLEAR_CYCLES-1; on the last count, ped_done SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-015 If veh_stop falls during WALK, the FSM SHALL enter CAUTION on the next edge with pd_counter forced to pd_free_cycles (abort walk, keep full caution).
REQ-016 A ped_button coinciding with the CLEAR-to-IDLE edge SHALL be latched, so the next phase follows without loss.
REQ-017 The 32-bit pd_total_cycles sum SHALL saturate at 32'hFFFF_FFFF rather than wrap.
REQ-018 Outside WALK/CAUTION/CLEAR, pd_counter SHALL hold 0.

Reset
REQ-019 On rst_n low, the block SHALL asynchronously force the following values, and hold them until the first clock edge after rst_n rises:
- state=IDLE
- req_pending=0, ped_req=0
- walk=0, dont_walk=1
- ped_done=0, pd_caution=0
- pd_counter=0, pd_free_cycles=0, pd_total_cycles=0
REQ-020 Reset asserted mid-phase SHALL abandon the phase and any pending request.

Configuration
REQ-021 With macro PED_ACCESSIBLE_EXTEND_EN defined, the extension feature SHALL be compiled in:
- An ext_button high during WALK, with no prior extension this phase, SHALL add EXT_CYCLES to both pd_free_cycles and pd_total_cycles on the next edge.
- Only one extension SHALL be granted per phase.
- ext_button high on the WALK-to-CAUTION edge SHALL be ignored.
REQ-022 Without PED_ACCESSIBLE_EXTEND_EN, ext_button SHALL be ignored and the extension logic SHALL be absent.

Verification
Bench parameters: WALK=4, CAUTION=3, CLEAR=2, EXT=2.
REQ-023 Nominal phase: ped_button pulse at cycle 0 with veh_stop=1 -> ped_req=1 at cycle 1; WALK for pd_counter 0..3; CAUTION for 4..6; CLEAR for 2 cycles; ped_done pulse on the last CLEAR cycle; IDLE follows, with ped_req=0.
REQ-024 Walk abort: veh_stop drops at WALK pd_counter=1 -> CAUTION next cycle with pd_counter=4, then 3 CAUTION cycles.
REQ-025 Extension with PED_ACCESSIBLE_EXTEND_EN: ext_button at WALK pd_counter=2 -> pd_free_cycles=6, pd_total_cycles=9; a second ext_button press has no effect.
REQ-026 Extension without PED_ACCESSIBLE_EXTEND_EN: the same stimulus as REQ-025 -> pd_free_cycles stays 4.
REQ-027 Back-to-back: ped_button on the ped_done cycle -> ped_req=1 in IDLE, and a new WALK starts the cycle after, with veh_stop=1.
REQ-028 Reset mid-CAUTION: rst_n low -> outputs at reset values immediately; no ped_done; a pending request is cleared.

Source files
------------

// File: rtl/pedestrian_phase_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pedestrian_phase_controller
// Brief    : Pedestrian crossing FSM (IDLE/WALK/CAUTION/CLEAR) with timer
//            display outputs. Optional accessible walk extension is compiled
//            in with macro PED_ACCESSIBLE_EXTEND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pedestrian_phase_controller #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned WALK_CYCLES    = 350_000_000,
    parameter int unsigned CAUTION_CYCLES = 500_000_000,
    parameter int unsigned CLEAR_CYCLES   = 100_000_000,
    parameter int unsigned EXT_CYCLES     = 150_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ped_button,
    input  logic        ext_button,
    input  logic        veh_stop,
    output logic        ped_req,
    output logic        walk,
    output logic        dont_walk,
    output logic        ped_done,
    output logic        pd_caution,
    output logic [31:0] pd_counter,
    output logic [31:0] pd_free_cycles,
    output logic [31:0] pd_total_cycles,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WALK    = 3'd1,
        S_CAUTION = 3'd2,
        S_CLEAR   = 3'd3
    } state_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    localparam logic [31:0] c_WALK_LEN    = 32'(WALK_CYCLES);
    localparam logic [31:0] c_CAUTION_LEN = 32'(CAUTION_CYCLES);
    localparam logic [31:0] c_TOTAL_LEN   = sat_add(c_WALK_LEN, c_CAUTION_LEN);
    localparam logic [31:0] c_CLEAR_LAST  = 32'(CLEAR_CYCLES - 1);

    if (CLK_FREQ == 0 || WALK_CYCLES == 0 || CAUTION_CYCLES == 0 || CLEAR_CYCLES == 0) begin : g_param_check
        $error("pedestrian_phase_controller: clock and phase durations must be non-zero");
    end

    state_t      r_state, w_state_next;
    logic        r_req_pending, w_req_pending_next;
    logic [31:0] r_counter, w_counter_next;
    logic [31:0] r_free, w_free_next;
    logic [31:0] r_total, w_total_next;

`ifdef PED_ACCESSIBLE_EXTEND_EN
    localparam logic [31:0] c_EXT_LEN = 32'(EXT_CYCLES);
    logic r_ext_used, w_ext_used_next;
`else
    logic unused_ext_button;
    assign unused_ext_button = ext_button;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_req_pending <= 1'b0;
            r_counter     <= 32'd0;
            r_free        <= 32'd0;
            r_total       <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_req_pending <= w_req_pending_next;
            r_counter     <= w_counter_next;
            r_free        <= w_free_next;
            r_total       <= w_total_next;
        end
    end

`ifdef PED_ACCESSIBLE_EXTEND_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_used <= 1'b0;
        end else begin
            r_ext_used <= w_ext_used_next;
        end
    end
`endif

    always_comb begin
        w_state_next       = r_state;
        w_req_pending_next = r_req_pending;
        w_counter_next     = r_counter;
        w_free_next        = r_free;
        w_total_next       = r_total;
`ifdef PED_ACCESSIBLE_EXTEND_EN
        w_ext_used_next    = r_ext_used;
`endif

        // Requests are latched everywhere but WALK, including the CLEAR-to-IDLE edge.
        if (ped_button && (r_state != S_WALK)) begin
            w_req_pending_next = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_counter_next = 32'd0;
                if (r_req_pending && veh_stop) begin
                    w_state_next       = S_WALK;
                    w_req_pending_next = 1'b0;
                    w_free_next        = c_WALK_LEN;
                    w_total_next       = c_TOTAL_LEN;
`ifdef PED_ACCESSIBLE_EXTEND_EN
                    w_ext_used_next    = 1'b0;
`endif
                end
            end
            S_WALK: begin
                // Losing veh_stop aborts the walk but keeps the full caution interval.
                if (!veh_stop || (r_counter == r_free - 32'd1)) begin
                    w_state_next   = S_CAUTION;
                    w_counter_next = r_free;
                end else begin
                    w_counter_next = r_counter + 32'd1;
`ifdef PED_ACCESSIBLE_EXTEND_EN
                    if (ext_button && !r_ext_used) begin
                        w_free_next     = sat_add(r_free, c_EXT_LEN);
                        w_total_next    = sat_add(r_total, c_EXT_LEN);
                        w_ext_used_next = 1'b1;
                    end
`endif
                end
            end
            S_CAUTION: begin
                if (r_counter == r_total - 32'd1) begin
                    w_state_next   = S_CLEAR;
                    w_counter_next = 32'd0;
                end else begin
                    w_counter_next = r_counter + 32'd1;
                end
            end
            S_CLEAR: begin
                if (r_counter == c_CLEAR_LAST) begin
                    w_state_next   = S_IDLE;
                    w_counter_next = 32'd0;
                end else begin
                    w_counter_next = r_counter + 32'd1;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_counter_next = 32'd0;
            end
        endcase
    end

    assign state           = r_state;
    assign ped_req         = r_req_pending;
    assign walk            = (r_state == S_WALK);
    assign dont_walk       = ~walk;
    assign pd_caution      = (r_state == S_WALK) || (r_state == S_CAUTION);
    assign ped_done        = (r_state == S_CLEAR) && (r_counter == c_CLEAR_LAST);
    assign pd_counter      = r_counter;
    assign pd_free_cycles  = r_free;
    assign pd_total_cycles = r_total;

endmodule
`default_nettype wire

// File: tb/tb_pedestrian_phase_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pedestrian_phase_controller
// Brief    : Directed self-checking bench (WALK=4, CAUTION=3, CLEAR=2, EXT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pedestrian_phase_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ped_button;
    logic        ext_button;
    logic        veh_stop;
    logic        ped_req;
    logic        walk;
    logic        dont_walk;
    logic        ped_done;
    logic        pd_caution;
    logic [31:0] pd_counter;
    logic [31:0] pd_free_cycles;
    logic [31:0] pd_total_cycles;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    pedestrian_phase_controller #(
        .CLK_FREQ       (100),
        .WALK_CYCLES    (4),
        .CAUTION_CYCLES (3),
        .CLEAR_CYCLES   (2),
        .EXT_CYCLES     (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ped_button      (ped_button),
        .ext_button      (ext_button),
        .veh_stop        (veh_stop),
        .ped_req         (ped_req),
        .walk            (walk),
        .dont_walk       (dont_walk),
        .ped_done        (ped_done),
        .pd_caution      (pd_caution),
        .pd_counter      (pd_counter),
        .pd_free_cycles  (pd_free_cycles),
        .pd_total_cycles (pd_total_cycles),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},  32'(state), 32'd0);
        check({tag, "_req"},    32'(ped_req), 32'd0);
        check({tag, "_walk"},   32'(walk), 32'd0);
        check({tag, "_dwalk"},  32'(dont_walk), 32'd1);
        check({tag, "_done"},   32'(ped_done), 32'd0);
        check({tag, "_caut"},   32'(pd_caution), 32'd0);
        check({tag, "_cnt"},    pd_counter, 32'd0);
        check({tag, "_free"},   pd_free_cycles, 32'd0);
        check({tag, "_total"},  pd_total_cycles, 32'd0);
    endtask

    task automatic check_sc(input string tag, input logic [2:0] st, input logic [31:0] cnt);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_cnt"},   pd_counter, cnt);
    endtask

    initial begin
        rst_n      = 1'b0;
        ped_button = 1'b0;
        ext_button = 1'b0;
        veh_stop   = 1'b1;
        #1;
        check_reset_values("rst_init");
        step();
        step();
        rst_n = 1'b1;
        step();
        check_sc("idle_after_rst", 3'd0, 32'd0);

        // Nominal phase
        ped_button = 1'b1;
        step();
        ped_button = 1'b0;
        check("nom_req", 32'(ped_req), 32'd1);
        check("nom_req_idle", 32'(state), 32'd0);
        step();
        check_sc("nom_w0", 3'd1, 32'd0);
        check("nom_w0_free", pd_free_cycles, 32'd4);
        check("nom_w0_total", pd_total_cycles, 32'd7);
        check("nom_w0_req", 32'(ped_req), 32'd0);
        check("nom_w0_walk", 32'(walk), 32'd1);
        check("nom_w0_dwalk", 32'(dont_walk), 32'd0);
        check("nom_w0_caut", 32'(pd_caution), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check_sc("nom_walk", 3'd1, 32'(i));
        end
        for (int i = 4; i <= 6; i++) begin
            step();
            check_sc("nom_caution", 3'd2, 32'(i));
            check("nom_caution_walk", 32'(walk), 32'd0);
            check("nom_caution_caut", 32'(pd_caution), 32'd1);
        end
        step();
        check_sc("nom_clr0", 3'd3, 32'd0);
        check("nom_clr0_caut", 32'(pd_caution), 32'd0);
        check("nom_clr0_done", 32'(ped_done), 32'd0);
        step();
        check_sc("nom_clr1", 3'd3, 32'd1);
        check("nom_clr1_done", 32'(ped_done), 32'd1);
        step();
        check_sc("nom_idle", 3'd0, 32'd0);
        check("nom_idle_done", 32'(ped_done), 32'd0);
        check("nom_idle_req", 32'(ped_req), 32'd0);

        // Walk abort
        ped_button = 1'b1;
        step();
        ped_button = 1'b0;
        step();
        step();
        check_sc("abort_w1", 3'd1, 32'd1);
        veh_stop = 1'b0;
        step();
        check_sc("abort_c4", 3'd2, 32'd4);
        check("abort_c4_dwalk", 32'(dont_walk), 32'd1);
        veh_stop = 1'b1;
        step();
        check_sc("abort_c5", 3'd2, 32'd5);
        step();
        check_sc("abort_c6", 3'd2, 32'd6);
        step();
        check_sc("abort_clr0", 3'd3, 32'd0);
        step();
        check("abort_done", 32'(ped_done), 32'd1);
        step();
        check_sc("abort_idle", 3'd0, 32'd0);

        // Extension request at WALK count 2, then a second press
        ped_button = 1'b1;
        step();
        ped_button = 1'b0;
        step();
        step();
        step();
        check_sc("ext_w2", 3'd1, 32'd2);
        ext_button = 1'b1;
        step();
        check_sc("ext_w3", 3'd1, 32'd3);
`ifdef PED_ACCESSIBLE_EXTEND_EN
        check("ext_free", pd_free_cycles, 32'd6);
        check("ext_total", pd_total_cycles, 32'd9);
        step();
        check_sc("ext_w4", 3'd1, 32'd4);
        check("ext_free_again", pd_free_cycles, 32'd6);
        check("ext_total_again", pd_total_cycles, 32'd9);
        ext_button = 1'b0;
        step();
        check_sc("ext_w5", 3'd1, 32'd5);
        step();
        check_sc("ext_c6", 3'd2, 32'd6);
`else
        check("noext_free", pd_free_cycles, 32'd4);
        check("noext_total", pd_total_cycles, 32'd7);
        step();
        check_sc("noext_c4", 3'd2, 32'd4);
        check("noext_free_again", pd_free_cycles, 32'd4);
        ext_button = 1'b0;
        step();
        check_sc("noext_c5", 3'd2, 32'd5);
`endif
        for (int i = 0; i < 40 && ped_done !== 1'b1; i++) begin
            step();
        end
        check("ext_phase_done", 32'(ped_done), 32'd1);
        check("ext_phase_done_state", 32'(state), 32'd3);

        // Back-to-back request on the ped_done cycle
        ped_button = 1'b1;
        step();
        ped_button = 1'b0;
        check_sc("b2b_idle", 3'd0, 32'd0);
        check("b2b_req", 32'(ped_req), 32'd1);
        check("b2b_done_low", 32'(ped_done), 32'd0);
        step();
        check_sc("b2b_w0", 3'd1, 32'd0);
        check("b2b_w0_req", 32'(ped_req), 32'd0);
        check("b2b_w0_free", pd_free_cycles, 32'd4);

        // Reset in the middle of CAUTION with a pending request
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check_sc("rst_c4", 3'd2, 32'd4);
        ped_button = 1'b1;
        step();
        ped_button = 1'b0;
        check("rst_c5_req", 32'(ped_req), 32'd1);
        check_sc("rst_c5", 3'd2, 32'd5);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_state", 32'(state), 32'd0);
            check("post_rst_done", 32'(ped_done), 32'd0);
            check("post_rst_req", 32'(ped_req), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
